// File: rtl/controle_centrifugacao.sv
// controle_centrifugacao: spin-cycle controller for the washing-machine datapath.
// Programmable hold time and target speed, linear ramps, lid pause with resume
// and an abort path that always ramps the motor down before releasing it.
// Optional feature macro: CENTRIF_DESBAL_EN (unbalance event counting and fault).
//
// Handshake: start is a level request. It is sampled in OCIOSO to begin a cycle,
// must stay high for the cycle to run to completion, and must drop in FIM before
// another cycle can begin. No other valid/ready pairing exists on this block.
module controle_centrifugacao #(
    parameter int TEMPO_W       = 8,
    parameter int VEL_W         = 4,
    parameter int PASSO_RAMPA   = 4,
    parameter int LIMITE_DESBAL = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [TEMPO_W-1:0] duracao,
    input  logic [VEL_W-1:0]   vel_alvo,
    input  logic               tampa_aberta,
    input  logic               desbalanceado,
    output logic [VEL_W-1:0]   velocidade,
    output logic               centrifugacao_ativa,
    output logic               concluido,
    output logic               erro_desbalanceio,
    output logic [2:0]         estado_dbg
);

    localparam int PRESC_W = (PASSO_RAMPA > 1) ? $clog2(PASSO_RAMPA) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PASSO_RAMPA - 1);

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        ACELERA    = 3'd1,
        MANTEM     = 3'd2,
        DESACELERA = 3'd3,
        PAUSA      = 3'd4,
        FIM        = 3'd5
    } estado_t;

    estado_t            estado, estado_prox;
    logic [VEL_W-1:0]   vel_prox;
    logic [VEL_W-1:0]   alvo_l, alvo_prox;
    logic [TEMPO_W-1:0] dur_l, dur_prox;
    logic [TEMPO_W-1:0] hold_cnt, hold_prox, hold_lim;
    logic [PRESC_W-1:0] presc, presc_prox;
    logic               abort_f, abort_prox;
    logic               erro_prox;
    logic               conc_prox, ativo_prox;
    logic               wrap;
    logic               falha_desbal;

    assign estado_dbg = estado;

`ifdef CENTRIF_DESBAL_EN
    localparam int DESB_W = $clog2(LIMITE_DESBAL + 1);
    localparam logic [DESB_W-1:0] DESB_MAX = DESB_W'(LIMITE_DESBAL);

    logic [DESB_W-1:0] desb_cnt, desb_prox;

    // Unbalance event counter: cleared on a new start, counts pulses while spinning up or holding.
    always_comb begin
        desb_prox    = desb_cnt;
        falha_desbal = 1'b0;
        if (estado == OCIOSO && start && !tampa_aberta) begin
            desb_prox = '0;
        end else if ((estado == ACELERA || estado == MANTEM) && desbalanceado) begin
            if (desb_cnt != DESB_MAX) begin
                desb_prox = desb_cnt + 1'b1;
            end
            if (int'(desb_cnt) + 1 >= LIMITE_DESBAL) begin
                falha_desbal = 1'b1;
            end
        end
    end

    // Unbalance counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            desb_cnt <= '0;
        end else begin
            desb_cnt <= desb_prox;
        end
    end
`else
    // Unbalance detection is not built; this term is constant 0.
    assign falha_desbal = 1'b0 & desbalanceado & (LIMITE_DESBAL > 0);
`endif

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        estado_prox = estado;
        vel_prox    = velocidade;
        alvo_prox   = alvo_l;
        dur_prox    = dur_l;
        hold_prox   = hold_cnt;
        abort_prox  = abort_f;
        erro_prox   = erro_desbalanceio;
        wrap        = (presc == PRESC_MAX);
        hold_lim    = (dur_l == '0) ? '0 : dur_l - 1'b1;

        case (estado)
            OCIOSO: begin
                if (start && !tampa_aberta) begin
                    alvo_prox   = vel_alvo;
                    dur_prox    = duracao;
                    hold_prox   = '0;
                    abort_prox  = 1'b0;
                    erro_prox   = 1'b0;
                    vel_prox    = '0;
                    estado_prox = (vel_alvo == '0) ? FIM : ACELERA;
                end
            end
            ACELERA: begin
                if (!start) begin
                    estado_prox = DESACELERA;
                    abort_prox  = 1'b1;
                end else if (falha_desbal) begin
                    estado_prox = DESACELERA;
                    abort_prox  = 1'b1;
                    erro_prox   = 1'b1;
                end else if (tampa_aberta) begin
                    estado_prox = PAUSA;
                end else if (velocidade >= alvo_l) begin
                    // Saturation guard: never step past the latched target.
                    estado_prox = MANTEM;
                end else if (wrap) begin
                    vel_prox = velocidade + 1'b1;
                    if ((velocidade + 1'b1) == alvo_l) begin
                        estado_prox = MANTEM;
                    end
                end
            end
            MANTEM: begin
                if (!start) begin
                    estado_prox = DESACELERA;
                    abort_prox  = 1'b1;
                end else if (falha_desbal) begin
                    estado_prox = DESACELERA;
                    abort_prox  = 1'b1;
                    erro_prox   = 1'b1;
                end else if (tampa_aberta) begin
                    // Hold count stays frozen so the hold resumes where it left off.
                    estado_prox = PAUSA;
                end else if (hold_cnt >= hold_lim) begin
                    estado_prox = DESACELERA;
                end else begin
                    hold_prox = hold_cnt + 1'b1;
                end
            end
            DESACELERA: begin
                if (velocidade == '0) begin
                    estado_prox = abort_f ? OCIOSO : FIM;
                end else if (wrap) begin
                    vel_prox = velocidade - 1'b1;
                    if (velocidade == VEL_W'(1)) begin
                        estado_prox = abort_f ? OCIOSO : FIM;
                    end
                end
            end
            PAUSA: begin
                if (!start) begin
                    // Already stopped: nothing left to ramp down.
                    if (velocidade == '0) begin
                        estado_prox = OCIOSO;
                    end else begin
                        estado_prox = DESACELERA;
                        abort_prox  = 1'b1;
                    end
                end else if (velocidade == '0) begin
                    if (!tampa_aberta) begin
                        estado_prox = ACELERA;
                    end
                end else if (wrap) begin
                    vel_prox = velocidade - 1'b1;
                end
            end
            FIM: begin
                if (!start) begin
                    estado_prox = OCIOSO;
                end
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase

        // Ramp prescaler restarts on every state change and only runs while ramping.
        if (estado_prox != estado) begin
            presc_prox = '0;
        end else if (estado == ACELERA || estado == DESACELERA || estado == PAUSA) begin
            presc_prox = wrap ? '0 : presc + 1'b1;
        end else begin
            presc_prox = '0;
        end

        ativo_prox = (estado_prox == ACELERA) || (estado_prox == MANTEM) ||
                     (estado_prox == DESACELERA) || (estado_prox == PAUSA);
        conc_prox  = (estado_prox == FIM) && (estado != FIM);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado              <= OCIOSO;
            velocidade          <= '0;
            alvo_l              <= '0;
            dur_l               <= '0;
            hold_cnt            <= '0;
            presc               <= '0;
            abort_f             <= 1'b0;
            erro_desbalanceio   <= 1'b0;
            centrifugacao_ativa <= 1'b0;
            concluido           <= 1'b0;
        end else begin
            estado              <= estado_prox;
            velocidade          <= vel_prox;
            alvo_l              <= alvo_prox;
            dur_l               <= dur_prox;
            hold_cnt            <= hold_prox;
            presc               <= presc_prox;
            abort_f             <= abort_prox;
            erro_desbalanceio   <= erro_prox;
            centrifugacao_ativa <= ativo_prox;
            concluido           <= conc_prox;
        end
    end

endmodule

// File: tb/tb_controle_centrifugacao.sv
// Bench for controle_centrifugacao: expected per-cycle outputs are composed from
// ramp/hold/pause segments derived from the cycle rules (default parameters).
module tb_controle_centrifugacao;

    localparam int TEMPO_W = 8;
    localparam int VEL_W   = 4;
    localparam int P       = 4;
    localparam logic [2:0] ST_OCIOSO = 3'd0;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               start;
    logic [TEMPO_W-1:0] duracao;
    logic [VEL_W-1:0]   vel_alvo;
    logic               tampa_aberta;
    logic               desbalanceado;
    logic [VEL_W-1:0]   velocidade;
    logic               centrifugacao_ativa;
    logic               concluido;
    logic               erro_desbalanceio;
    logic [2:0]         estado_dbg;

    int checks = 0;
    int errors = 0;

    logic [VEL_W-1:0] exp_vel_q[$];
    logic [0:0]       exp_ativo_q[$];
    logic [0:0]       exp_conc_q[$];
    logic [0:0]       exp_erro_q[$];

    controle_centrifugacao dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .start               (start),
        .duracao             (duracao),
        .vel_alvo            (vel_alvo),
        .tampa_aberta        (tampa_aberta),
        .desbalanceado       (desbalanceado),
        .velocidade          (velocidade),
        .centrifugacao_ativa (centrifugacao_ativa),
        .concluido           (concluido),
        .erro_desbalanceio   (erro_desbalanceio),
        .estado_dbg          (estado_dbg)
    );

    // clock / reset
    always #5 clock = ~clock;

    // ---------------- reference model: per-cycle segments ----------------
    task automatic model_clear();
        exp_vel_q.delete(); exp_ativo_q.delete(); exp_conc_q.delete(); exp_erro_q.delete();
    endtask

    task automatic push(input int v, input bit a, input bit c);
        exp_vel_q.push_back(VEL_W'(v));
        exp_ativo_q.push_back(a);
        exp_conc_q.push_back(c);
        exp_erro_q.push_back(1'b0);
    endtask

    // speed rises one level every P cycles from 0 to v
    task automatic seg_up(input int v);
        for (int i = 0; i < v * P; i++) push(i / P, 1'b1, 1'b0);
    endtask

    task automatic seg_hold(input int v, input int n);
        for (int i = 0; i < n; i++) push(v, 1'b1, 1'b0);
    endtask

    // speed falls one level every P cycles from v to 0
    task automatic seg_down(input int v);
        for (int i = 0; i < v * P; i++) push(v - i / P, 1'b1, 1'b0);
    endtask

    task automatic seg_zero_active(input int n);
        for (int i = 0; i < n; i++) push(0, 1'b1, 1'b0);
    endtask

    task automatic seg_idle(input bit first_conc, input int n);
        for (int i = 0; i < n; i++) push(0, 1'b0, (i == 0) ? first_conc : 1'b0);
    endtask

    // ---------------- driver ----------------
    task automatic begin_cycle(input int v, input int d);
        @(negedge clock);
        vel_alvo = VEL_W'(v);
        duracao  = TEMPO_W'(d);
        start    = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (velocidade !== '0 || centrifugacao_ativa !== 1'b0 || concluido !== 1'b0 ||
            erro_desbalanceio !== 1'b0 || estado_dbg !== ST_OCIOSO) begin
            errors++;
            $display("FAIL reset_state vel=%0d ativo=%0b conc=%0b erro=%0b st=%0d required 0/0/0/0/0",
                     velocidade, centrifugacao_ativa, concluido, erro_desbalanceio, estado_dbg);
        end
        reset_n = 1'b1;
        // reach MANTEM at speed 3 (entry + 12), then reset between clock edges
        begin_cycle(3, 20);
        repeat (14) @(negedge clock);
        checks++;
        if (velocidade !== 4'd3 || centrifugacao_ativa !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre vel=%0d ativo=%0b required 3/1", velocidade, centrifugacao_ativa);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (velocidade !== '0 || centrifugacao_ativa !== 1'b0 || concluido !== 1'b0 ||
            estado_dbg !== ST_OCIOSO) begin
            errors++;
            $display("FAIL reset_async vel=%0d ativo=%0b conc=%0b st=%0d required 0/0/0/0",
                     velocidade, centrifugacao_ativa, concluido, estado_dbg);
        end
        @(negedge clock);
        start   = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_normal();
        int v, d, n, extra;
        for (int r = 0; r < 10; r++) begin
            if (r == 0) begin v = 3; d = 5; end
            else begin v = $urandom_range(0, 15); d = $urandom_range(0, 25); end
            extra = $urandom_range(1, 4);
            model_clear();
            if (v == 0) begin
                seg_idle(1'b1, 1 + extra);
            end else begin
                seg_up(v); seg_hold(v, (d == 0) ? 1 : d); seg_down(v); seg_idle(1'b1, 1 + extra);
            end
            n = exp_vel_q.size();
            begin_cycle(v, d);
            for (int k = 0; k < n; k++) begin
                @(negedge clock);
                checks++;
                if (velocidade !== exp_vel_q[k] || centrifugacao_ativa !== exp_ativo_q[k] ||
                    concluido !== exp_conc_q[k] || erro_desbalanceio !== exp_erro_q[k]) begin
                    errors++;
                    $display("FAIL normal run=%0d k=%0d vel=%0d/%0d ativo=%0b/%0b conc=%0b/%0b erro=%0b/%0b (got/required)",
                             r, k, velocidade, exp_vel_q[k], centrifugacao_ativa, exp_ativo_q[k],
                             concluido, exp_conc_q[k], erro_desbalanceio, exp_erro_q[k]);
                end
                // latched inputs may wander; unbalance pulses are ignored in this build
                duracao  = TEMPO_W'($urandom_range(0, 255));
                vel_alvo = VEL_W'($urandom_range(0, 15));
`ifndef CENTRIF_DESBAL_EN
                desbalanceado = ($urandom_range(0, 7) == 0);
`endif
                if (k == n - 1) start = 1'b0;
            end
            desbalanceado = 1'b0;
            @(negedge clock);
            checks++;
            if (estado_dbg !== ST_OCIOSO || velocidade !== '0 || concluido !== 1'b0) begin
                errors++;
                $display("FAIL normal_release run=%0d st=%0d vel=%0d conc=%0b required 0/0/0",
                         r, estado_dbg, velocidade, concluido);
            end
        end
    endtask

    task automatic test_degenerate();
        int v, d, n;
        for (int c = 0; c < 2; c++) begin
            v = (c == 0) ? 0 : 2;
            d = (c == 0) ? 7 : 0;
            model_clear();
            if (v == 0) seg_idle(1'b1, 4);
            else begin seg_up(v); seg_hold(v, 1); seg_down(v); seg_idle(1'b1, 3); end
            n = exp_vel_q.size();
            begin_cycle(v, d);
            for (int k = 0; k < n; k++) begin
                @(negedge clock);
                checks++;
                if (velocidade !== exp_vel_q[k] || centrifugacao_ativa !== exp_ativo_q[k] ||
                    concluido !== exp_conc_q[k]) begin
                    errors++;
                    $display("FAIL degenerate case=%0d k=%0d vel=%0d/%0d ativo=%0b/%0b conc=%0b/%0b (got/required)",
                             c, k, velocidade, exp_vel_q[k], centrifugacao_ativa, exp_ativo_q[k],
                             concluido, exp_conc_q[k]);
                end
                if (k == n - 1) start = 1'b0;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_abort();
        int v, d, m, n, a;
        for (int r = 0; r < 3; r++) begin
            if (r == 0) begin v = 3; d = 5; m = 1; end
            else begin v = $urandom_range(2, 15); d = $urandom_range(3, 20); m = $urandom_range(0, d - 1); end
            a = v * P;
            model_clear();
            seg_up(v); seg_hold(v, m + 1); seg_down(v); seg_idle(1'b0, 4);
            n = exp_vel_q.size();
            begin_cycle(v, d);
            for (int k = 0; k < n; k++) begin
                @(negedge clock);
                checks++;
                if (velocidade !== exp_vel_q[k] || centrifugacao_ativa !== exp_ativo_q[k] ||
                    concluido !== exp_conc_q[k]) begin
                    errors++;
                    $display("FAIL abort run=%0d k=%0d vel=%0d/%0d ativo=%0b/%0b conc=%0b/%0b (got/required)",
                             r, k, velocidade, exp_vel_q[k], centrifugacao_ativa, exp_ativo_q[k],
                             concluido, exp_conc_q[k]);
                end
                if (k == a + m) start = 1'b0;
            end
            checks++;
            if (estado_dbg !== ST_OCIOSO) begin
                errors++;
                $display("FAIL abort_idle run=%0d st=%0d required %0d", r, estado_dbg, ST_OCIOSO);
            end
        end
    endtask

    task automatic test_lid();
        int v, d, h, hc, w, n, a, rel;
        for (int r = 0; r < 3; r++) begin
            if (r == 0) begin v = 3; d = 5; hc = 2; end
            else begin v = $urandom_range(1, 10); d = $urandom_range(1, 15); hc = $urandom_range(0, d - 1); end
            h   = (d == 0) ? 1 : d;
            w   = $urandom_range(0, 3);
            a   = v * P;
            rel = a + hc + 1 + v * P + w;
            model_clear();
            seg_up(v); seg_hold(v, hc + 1); seg_down(v); seg_zero_active(w + 1);
            seg_up(v); seg_hold(v, h - hc); seg_down(v); seg_idle(1'b1, 2);
            n = exp_vel_q.size();
            begin_cycle(v, d);
            for (int k = 0; k < n; k++) begin
                @(negedge clock);
                checks++;
                if (velocidade !== exp_vel_q[k] || centrifugacao_ativa !== exp_ativo_q[k] ||
                    concluido !== exp_conc_q[k]) begin
                    errors++;
                    $display("FAIL lid run=%0d k=%0d vel=%0d/%0d ativo=%0b/%0b conc=%0b/%0b (got/required)",
                             r, k, velocidade, exp_vel_q[k], centrifugacao_ativa, exp_ativo_q[k],
                             concluido, exp_conc_q[k]);
                end
                if (k == a + hc) tampa_aberta = 1'b1;
                if (k == rel) tampa_aberta = 1'b0;
                if (k == n - 1) start = 1'b0;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_desbal();
        int v, d, a, n, e_idx;
        v = 3; d = 10; a = v * P;
        model_clear();
`ifdef CENTRIF_DESBAL_EN
        seg_up(v); seg_hold(v, 5); seg_down(v); seg_idle(1'b0, 4);
        for (int i = a + 5; i < exp_erro_q.size(); i++) exp_erro_q[i] = 1'b1;
        e_idx = a + 5 + a;
`else
        seg_up(v); seg_hold(v, d); seg_down(v); seg_idle(1'b1, 4);
        e_idx = a + d + a;
`endif
        n = exp_vel_q.size();
        begin_cycle(v, d);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            checks++;
            if (velocidade !== exp_vel_q[k] || centrifugacao_ativa !== exp_ativo_q[k] ||
                concluido !== exp_conc_q[k] || erro_desbalanceio !== exp_erro_q[k]) begin
                errors++;
                $display("FAIL desbal k=%0d vel=%0d/%0d ativo=%0b/%0b conc=%0b/%0b erro=%0b/%0b (got/required)",
                         k, velocidade, exp_vel_q[k], centrifugacao_ativa, exp_ativo_q[k],
                         concluido, exp_conc_q[k], erro_desbalanceio, exp_erro_q[k]);
            end
            desbalanceado = (k == a || k == a + 2 || k == a + 4);
            if (k == e_idx - 1) start = 1'b0;
        end
        desbalanceado = 1'b0;
        // a fresh start clears any sticky fault
        begin_cycle(1, 1);
        @(negedge clock);
        checks++;
        if (erro_desbalanceio !== 1'b0 || centrifugacao_ativa !== 1'b1) begin
            errors++;
            $display("FAIL desbal_clear erro=%0b ativo=%0b required 0/1", erro_desbalanceio, centrifugacao_ativa);
        end
        repeat (12) @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        tampa_aberta  = 1'b0;
        desbalanceado = 1'b0;
        duracao       = '0;
        vel_alvo      = '0;
        test_reset();
        test_normal();
        test_degenerate();
        test_abort();
        test_lid();
        test_desbal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_centrifugacao.md
Name: controle_centrifugacao

Overview:
Parametrised spin-cycle controller for the washing-machine datapath. It replaces the fixed-time spin block with programmable duration, a target speed level, linear acceleration and deceleration ramps, a lid-open pause with resume, and a clean abort path. It is driven by the main wash sequencer through a level `start`, and it drives the motor speed-level bus.

Parameters:
TEMPO_W, 8, width of the hold-duration input and the hold counter
VEL_W, 4, width of the speed-level bus
PASSO_RAMPA, 4, clock cycles per ±1 speed step during ramps (≥1)
LIMITE_DESBAL, 3, unbalance events tolerated before fault (used only with the optional feature)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  level request; sampled high in OCIOSO begins a cycle; low mid-cycle aborts
duracao  in  TEMPO_W  hold time in cycles at target speed; latched on start
vel_alvo  in  VEL_W  target speed level; latched on start
tampa_aberta  in  1  lid open; forces a pause
desbalanceado  in  1  one-cycle unbalance event pulse
velocidade  out  VEL_W  current commanded speed level
centrifugacao_ativa  out  1  high in ACELERA, MANTEM, DESACELERA and PAUSA
concluido  out  1  one-cycle pulse on normal completion
erro_desbalanceio  out  1  sticky unbalance fault

Behaviour:
- Reset (async, reset_n=0):
  - state=OCIOSO; velocidade=0; centrifugacao_ativa=0; concluido=0; erro_desbalanceio=0.
  - All counters and latches cleared.
  - Takes effect immediately, including mid-cycle.
- States: OCIOSO, ACELERA, MANTEM, DESACELERA, PAUSA, FIM. All outputs are registered.
- OCIOSO:
  - On start=1 and tampa_aberta=0: latch duracao and vel_alvo, clear erro_desbalanceio, go to ACELERA.
  - If the latched vel_alvo is 0, go directly to FIM instead.
- Prescaler: counts 0..PASSO_RAMPA-1 in ACELERA, DESACELERA and PAUSA. It clears on every state change.
- ACELERA:
  - velocidade increments by 1 each time the prescaler wraps, so the first increment comes PASSO_RAMPA cycles after entry.
  - When velocidade equals the latched target, go to MANTEM with the hold counter at 0.
- MANTEM:
  - The hold counter increments every cycle.
  - When it reaches max(duracao,1)-1, go to DESACELERA. MANTEM therefore lasts max(duracao,1) cycles.
- DESACELERA:
  - velocidade decrements by 1 per prescaler wrap.
  - At 0, go to FIM on a normal run, or to OCIOSO on an abort or fault.
- FIM:
  - concluido is high for exactly the first cycle in FIM.
  - Stay in FIM until start=0, then go to OCIOSO. No retrigger while start stays high.
- Abort: start=0 in ACELERA, MANTEM or PAUSA → DESACELERA with the abort flag set. No concluido at the end.
- Lid: tampa_aberta=1 in ACELERA or MANTEM → PAUSA.
  - PAUSA ramps velocidade down to 0 at the ramp rate.
  - The hold counter is frozen during PAUSA.
  - When velocidade=0 and tampa_aberta=0, go to ACELERA. After re-reaching target, MANTEM resumes from the frozen hold count.
- Event priority in the same cycle: reset > abort (start=0) > unbalance fault > lid > normal progress.
- Arithmetic:
  - velocidade never wraps; it saturates at 0 and at the latched target.
  - The hold counter is TEMPO_W wide and never exceeds duracao.
- Inputs changed after latching (duracao, vel_alvo) have no effect until the next cycle starts.

Optional Feature:
- CENTRIF_DESBAL_EN defined:
  - A desbalanceado pulse in ACELERA or MANTEM increments the unbalance counter (cleared on start).
  - When the count reaches LIMITE_DESBAL: set erro_desbalanceio and go to DESACELERA with the abort flag.
  - erro_desbalanceio holds until the next start or reset.
- CENTRIF_DESBAL_EN undefined: desbalanceado is ignored, erro_desbalanceio is tied 0, and the unbalance counter is not built.

Test Plan:
1. Reset mid-cycle:
   - Stimulus: reset_n low while in MANTEM with velocidade=3.
   - Required: velocidade=0, centrifugacao_ativa=0, state OCIOSO at once without waiting for a clock edge.
2. Normal run, PASSO_RAMPA=4, vel_alvo=3, duracao=5, start held high:
   - velocidade reads 1, 2, 3 at entry+4, +8, +12.
   - MANTEM lasts 5 cycles, then velocidade reads 2, 1, 0 at 4-cycle intervals.
   - concluido pulses 1 cycle; centrifugacao_ativa=0 in FIM.
   - The block stays in FIM until start drops.
3. Abort: same setup, start dropped at the 2nd cycle of MANTEM → ramp 3→0 over 12 cycles, then OCIOSO, concluido never asserted.
4. Lid pause: tampa_aberta raised at hold count 2 of duracao=5, released after velocidade reaches 0 → re-ramp to 3, then exactly 3 more MANTEM cycles, then normal completion.
5. Degenerate inputs:
   - vel_alvo=0 → FIM next cycle, concluido pulse, velocidade stays 0.
   - duracao=0 with vel_alvo=2 → MANTEM lasts exactly 1 cycle.
6. With CENTRIF_DESBAL_EN, LIMITE_DESBAL=3:
   - Three desbalanceado pulses during MANTEM → erro_desbalanceio=1 on the cycle after the 3rd pulse, ramp to 0, OCIOSO, no concluido.
   - erro_desbalanceio clears on the next start.
   - Without the macro, the same stimulus completes normally.
